bcd_digit_counter_top: RTL and testbench
========================================

Name: bcd_digit_counter_top

Overview:
- Self-running single-digit 7-segment demo for a common-anode (CA) display.
- Divides the 50 MHz system clock to a 2 Hz rate and advances a 4-bit counter at that rate.
- Decodes the counter to active-low segments and drives the decimal point from count bit 0.
- Top-level board block; drives the display pins directly.

Parameters:
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- OUT_HZ, 2: counter advance rate and square-wave frequency.
- HALF_PERIOD, CLK_FREQ_HZ/(2*OUT_HZ) = 12_500_000: clk cycles per half period of the square wave. Overridable; must be >= 2.

Ports:
- clk, input, 1: system clock, 50 MHz. All logic is on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- Segments, output, 7: {g,f,e,d,c,b,a}, active-low (0 = segment lit).
- bp, output, 1: decimal point, active-low.
- SEL7, output, 1: digit anode select, active-low.
- clk2hz, output, 1: 2 Hz square wave, 50% duty (observability only).
- count, output, 4: current counter value (observability only).

Behaviour:
- Single clock domain; no derived clocks. Reset is synchronous, active-low.
- Reset (rst_n=0 at a clk edge):
  - div_cnt=0, clk2hz=0, count=0.
  - Therefore Segments=0x40, bp=1, SEL7=0.
- Divider:
  - div_cnt counts 0..HALF_PERIOD-1 and wraps to 0.
  - On the wrap cycle, clk2hz toggles.
  - tick = wrap AND (clk2hz==0), i.e. one clk cycle per rising edge of clk2hz.
- Counter:
  - On tick, count <= count+1, modulo 16 (15 wraps to 0).
  - count changes on the same clk edge at which clk2hz goes 0->1.
  - First increment occurs HALF_PERIOD clk edges after reset release; later increments every 2*HALF_PERIOD edges.
- Decoder: combinational from count; zero latency relative to count. Segments per value (hex, {g..a}):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - 10..15 = 0x7F (blank; invalid BCD).
- Decimal point: bp = ~count[0]. Lit on odd values, including odd invalid values 11, 13, 15.
- SEL7: constant 0 (digit always enabled), including during reset.
- Reset asserted mid-count: next clk edge returns all state to reset values; the divider phase restarts from 0.
- No X on any output after the first clk edge with rst_n=0.

Decomposition:
- Package seg7_pkg:
  - Ten active-low digit patterns SEG_0..SEG_9 and SEG_BLANK=7'h7F.
  - Default CLK_FREQ_HZ and OUT_HZ.
- Sub-module seg7_ca_decoder:
  - Purely combinational.
  - Inputs: 4-bit value and dp_in. Outputs: Segments, bp.
- Divider and counter stay inline in the top.

Test Plan (HALF_PERIOD=4 for simulation):
1. Hold rst_n=0 for 5 clks -> count=0, clk2hz=0, Segments=0x40, bp=1, SEL7=0.
2. Release reset -> clk2hz rises and count=1 at the 4th edge after release. Segments=0x79, bp=0 from that cycle.
3. Run 16 increments (8 clks apart) -> Segments follows the 0..9 table; 10..15 give 0x7F. bp alternates 1/0; count wraps 15->0 showing 0x40.
4. Check clk2hz over several periods -> high for exactly 4 clks and low for exactly 4 clks, period 8.
5. Assert rst_n=0 for 1 clk while count=7 at mid half-period -> count=0, clk2hz=0. Next increment occurs exactly 4 edges after release.
6. Check SEL7 across the whole run, including reset -> constantly 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Active-low 7-segment digit patterns ({g,f,e,d,c,b,a}) for a
//            common-anode display, plus the board's default clock rates.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;
    localparam int OUT_HZ_DEFAULT      = 2;

endpackage
`default_nettype wire

// File: rtl/seg7_ca_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_ca_decoder
// Brief    : Combinational BCD to active-low segment decoder; codes 10..15
//            blank the digit. Decimal point is driven active-low from dp_in.
// Revision : 1.0  initial release
// ============================================================================
module seg7_ca_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp_in,
    output logic [6:0] Segments,
    output logic       bp
);

    always_comb begin
        Segments = SEG_BLANK;
        case (value)
            4'd0:    Segments = SEG_0;
            4'd1:    Segments = SEG_1;
            4'd2:    Segments = SEG_2;
            4'd3:    Segments = SEG_3;
            4'd4:    Segments = SEG_4;
            4'd5:    Segments = SEG_5;
            4'd6:    Segments = SEG_6;
            4'd7:    Segments = SEG_7;
            4'd8:    Segments = SEG_8;
            4'd9:    Segments = SEG_9;
            default: Segments = SEG_BLANK;
        endcase
    end

    assign bp = ~dp_in;

endmodule
`default_nettype wire

// File: rtl/bcd_digit_counter_top.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter_top
// Brief    : Self-running single-digit demo: divides clk to OUT_HZ, advances a
//            4-bit counter on each rising edge of that wave, drives CA display.
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_counter_top
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int OUT_HZ      = OUT_HZ_DEFAULT,
    parameter int HALF_PERIOD = CLK_FREQ_HZ / (2 * OUT_HZ)
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] Segments,
    output logic       bp,
    output logic       SEL7,
    output logic       clk2hz,
    output logic [3:0] count
);

    localparam int              c_DIV_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(HALF_PERIOD - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_clk2hz;
    logic [3:0]         r_count;
    logic               w_wrap;
    logic               w_tick;

    assign w_wrap = (r_div_cnt == c_DIV_MAX);
    // Advance only on the low->high half of the square wave.
    assign w_tick = w_wrap && !r_clk2hz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_clk2hz  <= 1'b0;
            r_count   <= 4'd0;
        end else begin
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_clk2hz  <= ~r_clk2hz;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
            if (w_tick) begin
                r_count <= r_count + 4'd1;
            end
        end
    end

    seg7_ca_decoder u_decoder (
        .value    (r_count),
        .dp_in    (r_count[0]),
        .Segments (Segments),
        .bp       (bp)
    );

    assign SEL7   = 1'b0;
    assign clk2hz = r_clk2hz;
    assign count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_counter_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_counter_top
// Brief    : Directed bench with an edge-count model of the divider/counter
//            checked every cycle, plus hand-computed literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_digit_counter_top;

    localparam int HP = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] Segments;
    logic       bp;
    logic       SEL7;
    logic       clk2hz;
    logic [3:0] count;

    int tests = 0;
    int fails = 0;

    bcd_digit_counter_top #(.HALF_PERIOD(HP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Segments (Segments),
        .bp       (bp),
        .SEL7     (SEL7),
        .clk2hz   (clk2hz),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] exp_seg(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges since reset release determine the whole visible state.
    int n_edges = 0;
    bit model_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            n_edges     <= 0;
            model_valid <= 1'b1;
        end else begin
            n_edges <= n_edges + 1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            int m_cnt;
            int m_sq;
            m_cnt = ((n_edges + HP) / (2 * HP)) % 16;
            m_sq  = (n_edges / HP) % 2;
            check("model_count",  32'(count),    32'(m_cnt));
            check("model_clk2hz", 32'(clk2hz),   32'(m_sq));
            check("model_seg",    32'(Segments), 32'(exp_seg(m_cnt)));
            check("model_bp",     32'(bp),       32'((m_cnt % 2) == 0));
            check("model_sel7",   32'(SEL7),     32'(0));
        end
    end

    initial begin
        int hi;
        int lo;
        int guard;
        rst_n = 1'b0;

        repeat (5) @(negedge clk);
        check("rst_count", 32'(count),    32'h0);
        check("rst_clk2hz", 32'(clk2hz),  32'h0);
        check("rst_seg",   32'(Segments), 32'h40);
        check("rst_bp",    32'(bp),       32'h1);
        check("rst_sel7",  32'(SEL7),     32'h0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_first_count", 32'(count), 32'h0);
        @(negedge clk);
        check("first_count",  32'(count),    32'h1);
        check("first_clk2hz", 32'(clk2hz),   32'h1);
        check("first_seg",    32'(Segments), 32'h79);
        check("first_bp",     32'(bp),       32'h0);

        for (int i = 2; i <= 16; i++) begin
            repeat (2 * HP) @(negedge clk);
            check("step_count", 32'(count), 32'(i % 16));
            case (i)
                5:  check("seg_5",     32'(Segments), 32'h12);
                9:  check("seg_9",     32'(Segments), 32'h10);
                10: check("seg_10",    32'(Segments), 32'h7F);
                13: check("bp_13",     32'(bp),       32'h0);
                14: check("bp_14",     32'(bp),       32'h1);
                16: check("wrap_seg",  32'(Segments), 32'h40);
                default: ;
            endcase
        end

        // clk2hz just rose; measure two full periods.
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            lo = 0;
            while (clk2hz === 1'b1 && hi < 20) begin
                hi++;
                @(negedge clk);
            end
            while (clk2hz === 1'b0 && lo < 20) begin
                lo++;
                @(negedge clk);
            end
            check("sq_high_len", 32'(hi), 32'(HP));
            check("sq_low_len",  32'(lo), 32'(HP));
        end

        guard = 0;
        while (count !== 4'd7 && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        check("reach_7", 32'(count), 32'h7);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_count",  32'(count),  32'h0);
        check("midrst_clk2hz", 32'(clk2hz), 32'h0);
        repeat (3) @(negedge clk);
        check("midrst_hold", 32'(count), 32'h0);
        @(negedge clk);
        check("midrst_first", 32'(count), 32'h1);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
